// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32IM pipeline.
// Included first by every stage module.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  typedef enum logic [3:0] {
    ALU_PASS1 = 4'd0,
    ALU_PASS2 = 4'd1,
    ALU_ADD   = 4'd2,
    ALU_SUB   = 4'd3,
    ALU_AND   = 4'd4,
    ALU_OR    = 4'd5,
    ALU_XOR   = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_SLT   = 4'd10,
    ALU_MUL   = 4'd11,
    ALU_MULH  = 4'd12,
    ALU_DIV   = 4'd13,
    ALU_REM   = 4'd14,
    ALU_SLTU  = 4'd15
  } alu_con_e;

  localparam logic OP1_RS1 = 1'b0;
  localparam logic OP1_PC  = 1'b1;
  localparam logic OP2_RS2 = 1'b0;
  localparam logic OP2_IMM = 1'b1;

  typedef struct packed {
    logic     valid;
    logic     reg_write;
    logic     mem_read;
    logic     mem_write;
    logic     op1_sel;
    logic     op2_sel;
    alu_con_e alu_con;
  } ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand forwarding select.
// EX/MEM beats MEM/WB; x0 is never forwarded.
module fwd_mux #(
  parameter int W  = 32,
  parameter int AW = 5
) (
  input  logic [AW-1:0] rs_i,
  input  logic [W-1:0]  rf_data_i,
  input  logic [AW-1:0] ex_mem_rd_i,
  input  logic          ex_mem_we_i,
  input  logic [W-1:0]  ex_mem_res_i,
  input  logic [AW-1:0] mem_wb_rd_i,
  input  logic          mem_wb_we_i,
  input  logic [W-1:0]  mem_wb_res_i,
  output logic [W-1:0]  data_o
);

  logic hit_em;
  logic hit_mw;

  assign hit_em = ex_mem_we_i && (ex_mem_rd_i != '0)
               && (ex_mem_rd_i == rs_i);
  assign hit_mw = mem_wb_we_i && (mem_wb_rd_i != '0)
               && (mem_wb_rd_i == rs_i);

  always_comb begin
    data_o = rf_data_i;
    if (hit_em)      data_o = ex_mem_res_i;
    else if (hit_mw) data_o = mem_wb_res_i;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall,
// flush/hold handling and operand forwarding.
module id_ex_stage #(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int RA_W = riscv_pkg::RA_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [3:0]      id_alu_con,
  input  logic            id_op1_sel,
  input  logic            id_op2_sel,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            flush,
  input  logic            hold,
  input  logic [RA_W-1:0] ex_mem_rd,
  input  logic            ex_mem_reg_write,
  input  logic [XLEN-1:0] ex_mem_result,
  input  logic [RA_W-1:0] mem_wb_rd,
  input  logic            mem_wb_reg_write,
  input  logic [XLEN-1:0] mem_wb_result,
  output logic            stall_id,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [XLEN-1:0] alu_in_1,
  output logic [XLEN-1:0] alu_in_2,
  output logic [3:0]      alu_con,
  output logic [XLEN-1:0] ex_store_data
);

  import riscv_pkg::*;

  ex_ctrl_t        ctrl_q, ctrl_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [RA_W-1:0] rs1_q, rs1_d;
  logic [RA_W-1:0] rs2_q, rs2_d;
  logic [RA_W-1:0] rd_q, rd_d;

  logic            load_use;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // Load in EX whose result the ID instruction needs next cycle
  assign load_use = ctrl_q.valid && ctrl_q.mem_read
                 && (rd_q != '0) && id_valid
                 && ((rd_q == id_rs1) || (rd_q == id_rs2));

  assign stall_id = hold || (load_use && !flush);

  always_comb begin
    ctrl_d     = ctrl_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    if (hold) begin
      ctrl_d = ctrl_q;
    end else if (flush || load_use) begin
      ctrl_d     = '0;
      pc_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
    end else begin
      ctrl_d.valid     = id_valid;
      ctrl_d.reg_write = id_reg_write;
      ctrl_d.mem_read  = id_mem_read;
      ctrl_d.mem_write = id_mem_write;
      ctrl_d.op1_sel   = id_op1_sel;
      ctrl_d.op2_sel   = id_op2_sel;
      ctrl_d.alu_con   = alu_con_e'(id_alu_con);
      pc_d       = id_pc;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
    end
  end

  fwd_mux #(.W(XLEN), .AW(RA_W)) u_fwd_rs1 (
    .rs_i         (rs1_q),
    .rf_data_i    (rs1_data_q),
    .ex_mem_rd_i  (ex_mem_rd),
    .ex_mem_we_i  (ex_mem_reg_write),
    .ex_mem_res_i (ex_mem_result),
    .mem_wb_rd_i  (mem_wb_rd),
    .mem_wb_we_i  (mem_wb_reg_write),
    .mem_wb_res_i (mem_wb_result),
    .data_o       (fwd_rs1)
  );

  fwd_mux #(.W(XLEN), .AW(RA_W)) u_fwd_rs2 (
    .rs_i         (rs2_q),
    .rf_data_i    (rs2_data_q),
    .ex_mem_rd_i  (ex_mem_rd),
    .ex_mem_we_i  (ex_mem_reg_write),
    .ex_mem_res_i (ex_mem_result),
    .mem_wb_rd_i  (mem_wb_rd),
    .mem_wb_we_i  (mem_wb_reg_write),
    .mem_wb_res_i (mem_wb_result),
    .data_o       (fwd_rs2)
  );

  assign alu_in_1 = (ctrl_q.op1_sel == OP1_PC)  ? pc_q  : fwd_rs1;
  assign alu_in_2 = (ctrl_q.op2_sel == OP2_IMM) ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;

  assign ex_valid     = ctrl_q.valid;
  assign ex_pc        = pc_q;
  assign ex_rd        = rd_q;
  assign ex_reg_write = ctrl_q.reg_write;
  assign ex_mem_read  = ctrl_q.mem_read;
  assign ex_mem_write = ctrl_q.mem_write;
  assign alu_con      = ctrl_q.alu_con;

endmodule
